eeprom_block_read_seq: RTL and testbench
========================================

// Module: eeprom_block_read_seq
// PURPOSE
//  Sequences i2c_read_byte_eeprom to fetch a block of consecutive bytes (FMC ID, MAC, serial)
//  into a local register buffer. Issues one byte-read per address, retries on NACK errors,
//  guards each byte with a timeout. Sits between FMC config logic and the byte reader.
// PARAMETERS
//  MAX_BYTES      16       buffer depth; max bytes per block request
//  CNT_W          5        width of byte counts/indices, covers 0..MAX_BYTES
//  MAX_RETRY      3        extra attempts per byte after a reader error
//  GAP_CYCLES     8        idle cycles before each rd_start pulse; reader needs >=4 to reach WAIT1
//  TIMEOUT_CYCLES 8000000  max cycles rd_start->rd_byte_rdy, 64 ms @125 MHz; reader needs ~45 ms
// PORTS
//  clk            in   1        125-MHz clock
//  reset          in   1        asynchronous, active-high reset
//  start          in   1        1-cycle pulse: begin block read; ignored while busy=1
//  dev_ext        in   1        EEPROM uses extended (2-byte) addressing
//  dev_adr        in   7        EEPROM I2C device address
//  base_adr       in   8        first EEPROM location
//  num_bytes      in   CNT_W    bytes to read; clamped to MAX_BYTES
//  rd_start       out  1        to reader i2c_start_read (1-cycle pulse)
//  rd_dev_ext     out  1        to reader i2c_dev_ext (latched dev_ext)
//  rd_dev_adr     out  7        to reader i2c_dev_adr (latched dev_adr)
//  rd_reg_adr     out  8        to reader i2c_reg_adr = base + idx, mod 256
//  rd_byte_rdy    in   1        from reader: attempt finished (also after error)
//  rd_dat         in   8        from reader: data byte
//  rd_error       in   1        from reader: 1-cycle pulse, precedes rd_byte_rdy by 1 cycle
//  buf_adr        in   CNT_W    buffer read index
//  buf_dat        out  8        buffer[buf_adr], combinational; 0 if buf_adr>=MAX_BYTES
//  busy           out  1        block read in progress
//  done           out  1        1-cycle pulse at block end
//  fail           out  1        valid with done: block aborted
//  timeout        out  1        valid with done: abort cause was timeout
//  bytes_ok       out  CNT_W    bytes stored this block; holds until next start
// BEHAVIOUR
//  - Reset (async): all outputs 0, buffer cleared to 0, state IDLE, counters 0, GAP count preloaded.
//  - States: IDLE -> GAP -> ISSUE -> WAIT_BYTE -> (STORE -> GAP | RETRY -> GAP | FINISH) -> IDLE.
//  - IDLE: start=1 latches dev_ext, dev_adr, base_adr, min(num_bytes,MAX_BYTES); idx=0,
//    retry=0, bytes_ok=0, busy=1 next cycle. num_bytes=0: done=1, fail=0 next cycle, no rd_start.
//  - GAP: count GAP_CYCLES, then ISSUE. ISSUE: rd_start=1 for exactly 1 cycle, load timer.
//  - WAIT_BYTE: rd_error=1 sets err_seen sticky. On rd_byte_rdy:
//      err_seen=0 -> STORE: buffer[idx]<=rd_dat, idx++, bytes_ok++, retry=0;
//        idx==count -> FINISH(fail=0) else GAP.
//      err_seen=1, retry<MAX_RETRY -> RETRY: retry++, clear err_seen, GAP, same idx.
//      err_seen=1, retry==MAX_RETRY -> FINISH(fail=1, timeout=0).
//  - Timer expiry in WAIT_BYTE, no rd_byte_rdy -> FINISH(fail=1, timeout=1); no retry,
//    reader state unknown. Simultaneous expiry and rd_byte_rdy: rd_byte_rdy wins.
//  - FINISH: done=1 one cycle, busy=0 same cycle; fail/timeout held until next start.
//  - rd_byte_rdy/rd_error outside WAIT_BYTE ignored. start while busy ignored.
//  - rd_reg_adr = base_adr + idx, 8-bit wrap (base 0xFE, 4 bytes -> FE,FF,00,01).
//  - Latency per byte: GAP_CYCLES + 1 + reader time + 1 (STORE).
//  - Buffer entries >= bytes_ok keep stale data from prior blocks; not cleared on start.
//  - Reset mid-operation: immediate return to reset state; the reader shares reset.
// STRUCTURE
//  - Shared package eeprom_pkg: state encodings, default GAP/TIMEOUT constants, 10-ms pause
//    count (also used by i2c_read_byte_eeprom).
//  - Single module; timer, gap counter, buffer array inline. No sub-module required.
// TESTING
//  Bench uses a behavioural byte-reader model with programmable latency/error/hang; TIMEOUT_CYCLES=2000.
//  1 base=0x10,num=4, model returns adr^0xA5 -> rd_reg_adr 10..13, buf={B5,B4,B7,B6}, done,fail=0,ok=4
//  2 base=0xFE,num=3 -> addresses FE,FF,00; bytes_ok=3; no gap < GAP_CYCLES between rd_start pulses
//  3 error on byte 1 twice then success -> 3 rd_start for adr base+1, fail=0, bytes_ok=num
//  4 error on byte 2 every attempt -> 4 attempts (1+MAX_RETRY), done, fail=1, timeout=0, bytes_ok=2
//  5 model hangs on byte 0 -> done at 2000 cycles after rd_start, fail=1, timeout=1, bytes_ok=0
//  6 num=0 -> done next cycle, no rd_start; num=31 -> clamped, 16 reads; reset mid-byte -> all outputs 0

Source files
------------

// File: rtl/eeprom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eeprom_pkg: shared FSM encodings and timing constants for the FMC EEPROM   |
// | block reader and the byte reader.          Revision: 1.0                   |
// +----------------------------------------------------------------------------+
package eeprom_pkg;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_gap    = 3'd1;
  localparam logic [2:0] c_st_issue  = 3'd2;
  localparam logic [2:0] c_st_wait   = 3'd3;
  localparam logic [2:0] c_st_store  = 3'd4;
  localparam logic [2:0] c_st_retry  = 3'd5;
  localparam logic [2:0] c_st_finish = 3'd6;

  localparam int c_gap_cycles_def     = 8;
  localparam int c_timeout_cycles_def = 8_000_000;
  // 10 ms at 125 MHz, the write-cycle pause the byte reader also honours
  localparam int c_pause_10ms_cycles  = 1_250_000;

endpackage
`default_nettype wire

// File: rtl/eeprom_block_read_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eeprom_block_read_seq: fetches a block of consecutive EEPROM bytes via the |
// | byte reader into a local buffer, with per-byte retry and timeout.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module eeprom_block_read_seq
  import eeprom_pkg::*;
#(
  parameter int MAX_BYTES      = 16,
  parameter int CNT_W          = 5,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = c_gap_cycles_def,
  parameter int TIMEOUT_CYCLES = c_timeout_cycles_def
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dev_ext,
  input  logic [6:0]       dev_adr,
  input  logic [7:0]       base_adr,
  input  logic [CNT_W-1:0] num_bytes,
  output logic             rd_start,
  output logic             rd_dev_ext,
  output logic [6:0]       rd_dev_adr,
  output logic [7:0]       rd_reg_adr,
  input  logic             rd_byte_rdy,
  input  logic [7:0]       rd_dat,
  input  logic             rd_error,
  input  logic [CNT_W-1:0] buf_adr,
  output logic [7:0]       buf_dat,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] bytes_ok
);

  localparam int c_idx_w = $clog2(MAX_BYTES);
  localparam int c_rty_w = $clog2(MAX_RETRY + 1);
  localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
  localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]         r_state;
  logic               r_dev_ext;
  logic [6:0]         r_dev_adr;
  logic [7:0]         r_base;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_idx;
  logic [c_rty_w-1:0] r_retry;
  logic               r_err;
  logic [c_gap_w-1:0] r_gap;
  logic [c_tmr_w-1:0] r_timer;
  logic               r_fail;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_bytes_ok;
  logic [7:0]         r_buf [MAX_BYTES];

  logic [CNT_W-1:0]   w_clamped;
  logic               w_err;

  assign w_clamped = (num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : num_bytes;
  // rd_error may coincide with rd_byte_rdy on an early reader; treat it as sticky either way
  assign w_err     = r_err | rd_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_dev_ext  <= 1'b0;
      r_dev_adr  <= '0;
      r_base     <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_err      <= 1'b0;
      r_gap      <= c_gap_w'(GAP_CYCLES);
      r_timer    <= '0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_bytes_ok <= '0;
      for (int i = 0; i < MAX_BYTES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_dev_ext  <= dev_ext;
            r_dev_adr  <= dev_adr;
            r_base     <= base_adr;
            r_count    <= w_clamped;
            r_idx      <= '0;
            r_retry    <= '0;
            r_err      <= 1'b0;
            r_bytes_ok <= '0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_gap      <= c_gap_w'(GAP_CYCLES);
            r_state    <= (w_clamped == '0) ? c_st_finish : c_st_gap;
          end
        end
        c_st_gap: begin
          if (r_gap == c_gap_w'(1)) r_state <= c_st_issue;
          else                      r_gap   <= r_gap - 1'b1;
        end
        c_st_issue: begin
          // loaded one short so done lands TIMEOUT_CYCLES after the rd_start cycle
          r_timer <= c_tmr_w'(TIMEOUT_CYCLES - 1);
          r_err   <= 1'b0;
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          if (rd_byte_rdy) begin
            if (!w_err) begin
              r_buf[r_idx[c_idx_w-1:0]] <= rd_dat;
              r_idx      <= r_idx + 1'b1;
              r_bytes_ok <= r_bytes_ok + 1'b1;
              r_retry    <= '0;
              r_state    <= c_st_store;
            end else if (r_retry < c_rty_w'(MAX_RETRY)) begin
              r_state <= c_st_retry;
            end else begin
              r_fail    <= 1'b1;
              r_timeout <= 1'b0;
              r_state   <= c_st_finish;
            end
          end else begin
            if (rd_error) r_err <= 1'b1;
            if (r_timer == c_tmr_w'(1)) begin
              r_fail    <= 1'b1;
              r_timeout <= 1'b1;
              r_state   <= c_st_finish;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
        end
        c_st_store: begin
          r_gap   <= c_gap_w'(GAP_CYCLES);
          r_state <= (r_idx == r_count) ? c_st_finish : c_st_gap;
        end
        c_st_retry: begin
          r_retry <= r_retry + 1'b1;
          r_err   <= 1'b0;
          r_gap   <= c_gap_w'(GAP_CYCLES);
          r_state <= c_st_gap;
        end
        c_st_finish: r_state <= c_st_idle;
        default:     r_state <= c_st_idle;
      endcase
    end
  end

  assign rd_start   = (r_state == c_st_issue);
  assign rd_dev_ext = r_dev_ext;
  assign rd_dev_adr = r_dev_adr;
  assign rd_reg_adr = r_base + 8'(r_idx);
  assign buf_dat    = (buf_adr < CNT_W'(MAX_BYTES)) ? r_buf[buf_adr[c_idx_w-1:0]] : 8'h00;
  assign busy       = (r_state != c_st_idle) && (r_state != c_st_finish);
  assign done       = (r_state == c_st_finish);
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign bytes_ok   = r_bytes_ok;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_block_read_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eeprom_block_read_seq: vector table plus behavioural byte reader with   |
// | programmable latency, error and hang.      Revision: 1.0                   |
// +----------------------------------------------------------------------------+
module tb_eeprom_block_read_seq;

  localparam int GAP  = 8;
  localparam int TMO  = 2000;
  localparam int LAT  = 4;
  localparam int MAXB = 16;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dev_ext;
  logic [6:0] dev_adr;
  logic [7:0] base_adr;
  logic [4:0] num_bytes;
  logic       rd_start;
  logic       rd_dev_ext;
  logic [6:0] rd_dev_adr;
  logic [7:0] rd_reg_adr;
  logic       rd_byte_rdy;
  logic [7:0] rd_dat;
  logic       rd_error;
  logic [4:0] buf_adr;
  logic [7:0] buf_dat;
  logic       busy;
  logic       done;
  logic       fail;
  logic       timeout;
  logic [4:0] bytes_ok;

  eeprom_block_read_seq #(
    .MAX_BYTES(MAXB), .CNT_W(5), .MAX_RETRY(MAXR),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dev_ext(dev_ext), .dev_adr(dev_adr),
    .base_adr(base_adr), .num_bytes(num_bytes), .rd_start(rd_start),
    .rd_dev_ext(rd_dev_ext), .rd_dev_adr(rd_dev_adr), .rd_reg_adr(rd_reg_adr),
    .rd_byte_rdy(rd_byte_rdy), .rd_dat(rd_dat), .rd_error(rd_error),
    .buf_adr(buf_adr), .buf_dat(buf_dat), .busy(busy), .done(done), .fail(fail),
    .timeout(timeout), .bytes_ok(bytes_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // byte reader model
  int m_base     = 0;
  int m_err_off  = -1;
  int m_err_times = 0;
  int m_hang_off = -1;
  int attempts [256];
  int log_adr [$];
  int log_cyc [$];
  int m_a, m_off;
  bit m_do_err;

  initial begin
    rd_byte_rdy = 1'b0;
    rd_error    = 1'b0;
    rd_dat      = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_start === 1'b1) begin
        m_a      = int'(rd_reg_adr);
        m_off    = (m_a - m_base) & 255;
        m_do_err = (m_off == m_err_off) && (attempts[m_a] < m_err_times);
        log_adr.push_back(m_a);
        log_cyc.push_back(cyc);
        attempts[m_a]++;
        if (m_off != m_hang_off) begin
          repeat (LAT - 1) @(negedge clk);
          rd_error = m_do_err;
          @(negedge clk);
          rd_error    = 1'b0;
          rd_byte_rdy = 1'b1;
          rd_dat      = 8'(m_a ^ 8'hA5);
          @(negedge clk);
          rd_byte_rdy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int base; int num; int err_off; int err_times; int hang_off;
    int exp_ok; int exp_fail; int exp_tmo; int exp_starts;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int v);
    vec_t t = vecs[v];
    int s_cyc, d_cyc, n, last;
    int exp_q [$];
    bit stop;
    log_adr.delete();
    log_cyc.delete();
    foreach (attempts[i]) attempts[i] = 0;
    m_base = t.base; m_err_off = t.err_off; m_err_times = t.err_times; m_hang_off = t.hang_off;

    @(negedge clk);
    dev_ext = v[0]; dev_adr = 7'(8'h50 + v); base_adr = 8'(t.base); num_bytes = 5'(t.num);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0; dev_ext = 1'b0; dev_adr = '0; base_adr = '0; num_bytes = '0;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    d_cyc = cyc;
    check($sformatf("v%0d done_seen", v), done, 1);
    check($sformatf("v%0d busy_at_done", v), busy, 0);
    check($sformatf("v%0d fail", v), fail, t.exp_fail);
    check($sformatf("v%0d timeout", v), timeout, t.exp_tmo);
    check($sformatf("v%0d bytes_ok", v), bytes_ok, t.exp_ok);
    check($sformatf("v%0d rd_dev_adr", v), rd_dev_adr, (8'h50 + v) & 8'h7F);
    check($sformatf("v%0d rd_dev_ext", v), rd_dev_ext, v & 1);
    check($sformatf("v%0d num_starts", v), log_adr.size(), t.exp_starts);
    if (t.num == 0) check($sformatf("v%0d zero_len_latency", v), d_cyc - s_cyc, 1);
    if (log_cyc.size() > 0) check($sformatf("v%0d first_start_lat", v), log_cyc[0] - s_cyc, GAP + 1);
    for (int i = 1; i < log_cyc.size(); i++)
      check($sformatf("v%0d start_spacing%0d", v, i), log_cyc[i] - log_cyc[i-1], LAT + GAP + 2);

    stop = 1'b0;
    for (int i = 0; i < ((t.num > MAXB) ? MAXB : t.num) && !stop; i++) begin
      if (i == t.hang_off) begin
        exp_q.push_back((t.base + i) & 255);
        stop = 1'b1;
      end else if (i == t.err_off) begin
        for (int k = 0; k < ((t.err_times > MAXR) ? MAXR + 1 : t.err_times + 1); k++)
          exp_q.push_back((t.base + i) & 255);
        if (t.err_times > MAXR) stop = 1'b1;
      end else begin
        exp_q.push_back((t.base + i) & 255);
      end
    end
    for (int i = 0; i < exp_q.size() && i < log_adr.size(); i++)
      check($sformatf("v%0d rd_reg_adr%0d", v, i), log_adr[i], exp_q[i]);
    if (t.hang_off >= 0 && log_cyc.size() > 0) begin
      last = log_cyc[log_cyc.size() - 1];
      check($sformatf("v%0d timeout_cycles", v), d_cyc - last, TMO);
    end

    @(negedge clk);
    check($sformatf("v%0d done_pulse_end", v), done, 0);
    check($sformatf("v%0d fail_held", v), fail, t.exp_fail);
    for (int i = 0; i < t.exp_ok; i++) begin
      buf_adr = 5'(i);
      #1;
      check($sformatf("v%0d buf%0d", v, i), buf_dat, ((t.base + i) & 255) ^ 8'hA5);
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; dev_ext = 1'b0; dev_adr = '0; base_adr = '0;
    num_bytes = '0; buf_adr = '0;

    vecs[0] = '{base: 8'h10, num: 4,  err_off: -1, err_times: 0,  hang_off: -1, exp_ok: 4,  exp_fail: 0, exp_tmo: 0, exp_starts: 4};
    vecs[1] = '{base: 8'hFE, num: 3,  err_off: -1, err_times: 0,  hang_off: -1, exp_ok: 3,  exp_fail: 0, exp_tmo: 0, exp_starts: 3};
    vecs[2] = '{base: 8'h20, num: 4,  err_off: 1,  err_times: 2,  hang_off: -1, exp_ok: 4,  exp_fail: 0, exp_tmo: 0, exp_starts: 6};
    vecs[3] = '{base: 8'h30, num: 5,  err_off: 2,  err_times: 99, hang_off: -1, exp_ok: 2,  exp_fail: 1, exp_tmo: 0, exp_starts: 6};
    vecs[4] = '{base: 8'h40, num: 2,  err_off: -1, err_times: 0,  hang_off: 0,  exp_ok: 0,  exp_fail: 1, exp_tmo: 1, exp_starts: 1};
    vecs[5] = '{base: 8'h00, num: 0,  err_off: -1, err_times: 0,  hang_off: -1, exp_ok: 0,  exp_fail: 0, exp_tmo: 0, exp_starts: 0};
    vecs[6] = '{base: 8'h50, num: 31, err_off: -1, err_times: 0,  hang_off: -1, exp_ok: 16, exp_fail: 0, exp_tmo: 0, exp_starts: 16};

    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst fail", fail, 0);
    check("rst rd_start", rd_start, 0);
    check("rst bytes_ok", bytes_ok, 0);
    check("rst buf_dat", buf_dat, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_vec(v);
      if (v == 1) begin
        buf_adr = 5'd3;
        #1;
        check("stale_buf3", buf_dat, 8'hB6);
        buf_adr = 5'd16;
        #1;
        check("buf_out_of_range", buf_dat, 8'h00);
      end
    end

    // reset while a byte is outstanding
    log_adr.delete();
    log_cyc.delete();
    m_base = 8'h60; m_err_off = -1; m_hang_off = 0;
    @(negedge clk);
    dev_ext = 1'b1; dev_adr = 7'h3C; base_adr = 8'h60; num_bytes = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (log_adr.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid rd_start_seen", log_adr.size(), 1);
    repeat (5) @(negedge clk);
    check("mid busy_before", busy, 1);
    buf_adr = 5'd0;
    reset = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst fail", fail, 0);
    check("mid rst timeout", timeout, 0);
    check("mid rst bytes_ok", bytes_ok, 0);
    check("mid rst rd_start", rd_start, 0);
    check("mid rst rd_reg_adr", rd_reg_adr, 0);
    check("mid rst rd_dev_adr", rd_dev_adr, 0);
    check("mid rst rd_dev_ext", rd_dev_ext, 0);
    check("mid rst buf_dat", buf_dat, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
